// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. Accepts one
// operation at a time, waits ALU_LAT cycles, then returns a tagged response.
module alu_arbiter #(
  parameter int ALU_LAT = 1,
  parameter int W       = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [2:0]   op0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [2:0]   op1,
  output logic         ack1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         busy,
  output logic [7:0]   op_count
);

  // Handshake: a requester holds reqN high with stable operands until ackN
  // pulses for one cycle; the operands are latched on that same edge.
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic [7:0]   op_count_q, op_count_d;
  logic         last_id_q, last_id_d;
  logic         id_q, id_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         grant1;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    op_count_d   = op_count_q;
    last_id_d    = last_id_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    // Port 1 wins when alone, or when both ask and port 0 was served last.
    grant1       = req1 && (!req0 || (last_id_q == 1'b0));

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          alu_a_d   = grant1 ? a1 : a0;
          alu_b_d   = grant1 ? b1 : b0;
          alu_op_d  = grant1 ? op1 : op0;
          last_id_d = grant1;
          id_d      = grant1;
          ack0_d    = !grant1;
          ack1_d    = grant1;
          cnt_d     = 3'(ALU_LAT);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd1) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          op_count_d   = (op_count_q == 8'hFF) ? op_count_q : op_count_q + 8'd1;
          cnt_d        = 3'd0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      op_count_q   <= '0;
      last_id_q    <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      op_count_q   <= op_count_d;
      last_id_q    <= last_id_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign op_count   = op_count_q;
  assign busy       = (state_q == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=3,
// both fed by a small behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // {flags[3:0] = C,V,Z,N ; result[6:0]}; op 000 adds, every other op XORs.
  function automatic logic [10:0] alu_model(input logic [6:0] a, input logic [6:0] b,
                                            input logic [2:0] op);
    logic [7:0] s;
    logic [6:0] r;
    logic c, v;
    if (op == 3'b000) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[6:0];
      c = s[7];
      v = (a[6] == b[6]) && (r[6] != a[6]);
    end else begin
      r = a ^ b;
      c = 1'b0;
      v = 1'b0;
    end
    return {c, v, (r == 7'd0), r[6], r};
  endfunction

  // Instance with ALU_LAT = 1
  logic       d1_req0 = 0, d1_req1 = 0;
  logic [6:0] d1_a0 = 0, d1_b0 = 0, d1_a1 = 0, d1_b1 = 0;
  logic [2:0] d1_op0 = 0, d1_op1 = 0;
  logic       d1_ack0, d1_ack1, d1_rsp_valid, d1_rsp_id, d1_busy;
  logic [6:0] d1_alu_a, d1_alu_b, d1_alu_result, d1_rsp_result;
  logic [2:0] d1_alu_op;
  logic [3:0] d1_alu_flags, d1_rsp_flags;
  logic [7:0] d1_op_count;
  assign {d1_alu_flags, d1_alu_result} = alu_model(d1_alu_a, d1_alu_b, d1_alu_op);

  alu_arbiter #(.ALU_LAT(1), .W(7)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(d1_req0), .a0(d1_a0), .b0(d1_b0), .op0(d1_op0), .ack0(d1_ack0),
    .req1(d1_req1), .a1(d1_a1), .b1(d1_b1), .op1(d1_op1), .ack1(d1_ack1),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
    .alu_result(d1_alu_result), .alu_flags(d1_alu_flags),
    .rsp_valid(d1_rsp_valid), .rsp_id(d1_rsp_id), .rsp_result(d1_rsp_result),
    .rsp_flags(d1_rsp_flags), .busy(d1_busy), .op_count(d1_op_count)
  );

  // Instance with ALU_LAT = 3
  logic       d3_req0 = 0, d3_req1 = 0;
  logic [6:0] d3_a0 = 0, d3_b0 = 0, d3_a1 = 0, d3_b1 = 0;
  logic [2:0] d3_op0 = 0, d3_op1 = 0;
  logic       d3_ack0, d3_ack1, d3_rsp_valid, d3_rsp_id, d3_busy;
  logic [6:0] d3_alu_a, d3_alu_b, d3_alu_result, d3_rsp_result;
  logic [2:0] d3_alu_op;
  logic [3:0] d3_alu_flags, d3_rsp_flags;
  logic [7:0] d3_op_count;
  assign {d3_alu_flags, d3_alu_result} = alu_model(d3_alu_a, d3_alu_b, d3_alu_op);

  alu_arbiter #(.ALU_LAT(3), .W(7)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(d3_req0), .a0(d3_a0), .b0(d3_b0), .op0(d3_op0), .ack0(d3_ack0),
    .req1(d3_req1), .a1(d3_a1), .b1(d3_b1), .op1(d3_op1), .ack1(d3_ack1),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
    .alu_result(d3_alu_result), .alu_flags(d3_alu_flags),
    .rsp_valid(d3_rsp_valid), .rsp_id(d3_rsp_id), .rsp_result(d3_rsp_result),
    .rsp_flags(d3_rsp_flags), .busy(d3_busy), .op_count(d3_op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       port;
    logic [6:0] a;
    logic [6:0] b;
    logic [2:0] op;
    logic [6:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int found;
    logic ack_act, ack_oth;
    logic [2:0] ph_exp;

    vecs[0] = '{1'b0, 7'h05, 7'h03, 3'b000, 7'h08, 4'b0000};
    vecs[1] = '{1'b1, 7'h7F, 7'h01, 3'b000, 7'h00, 4'b1010};
    vecs[2] = '{1'b0, 7'h20, 7'h20, 3'b000, 7'h40, 4'b0101};
    vecs[3] = '{1'b1, 7'h55, 7'h2A, 3'b011, 7'h7F, 4'b0001};
    vecs[4] = '{1'b0, 7'h33, 7'h33, 3'b101, 7'h00, 4'b0010};
    vecs[5] = '{1'b1, 7'h60, 7'h60, 3'b000, 7'h40, 4'b1001};

    // Reset values
    #1;
    chk("rst_alu_a", 32'(d1_alu_a), 32'd0);
    chk("rst_alu_b", 32'(d1_alu_b), 32'd0);
    chk("rst_alu_op", 32'(d1_alu_op), 32'd0);
    chk("rst_acks", 32'({d1_ack0, d1_ack1}), 32'd0);
    chk("rst_rsp", 32'({d1_rsp_valid, d1_rsp_id, d1_rsp_result, d1_rsp_flags}), 32'd0);
    chk("rst_busy_cnt", 32'({d1_busy, d1_op_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single transactions from the vector table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].port) begin
        d1_req1 = 1'b1; d1_a1 = vecs[i].a; d1_b1 = vecs[i].b; d1_op1 = vecs[i].op;
      end else begin
        d1_req0 = 1'b1; d1_a0 = vecs[i].a; d1_b0 = vecs[i].b; d1_op0 = vecs[i].op;
      end
      step();
      ack_act = vecs[i].port ? d1_ack1 : d1_ack0;
      ack_oth = vecs[i].port ? d1_ack0 : d1_ack1;
      chk($sformatf("v%0d_ack", i), 32'(ack_act), 32'd1);
      chk($sformatf("v%0d_ack_other", i), 32'(ack_oth), 32'd0);
      chk($sformatf("v%0d_alu_in", i), 32'({d1_alu_a, d1_alu_b, d1_alu_op}),
          32'({vecs[i].a, vecs[i].b, vecs[i].op}));
      chk($sformatf("v%0d_busy", i), 32'(d1_busy), 32'd1);
      // Drop the request and disturb the operands; the op in flight must not notice.
      d1_req0 = 1'b0; d1_req1 = 1'b0;
      d1_a0 = ~vecs[i].a; d1_a1 = ~vecs[i].a; d1_b0 = ~vecs[i].b; d1_b1 = ~vecs[i].b;
      step();
      chk($sformatf("v%0d_rsp_valid", i), 32'(d1_rsp_valid), 32'd1);
      chk($sformatf("v%0d_rsp_id", i), 32'(d1_rsp_id), 32'(vecs[i].port));
      chk($sformatf("v%0d_rsp_result", i), 32'(d1_rsp_result), 32'(vecs[i].res));
      chk($sformatf("v%0d_rsp_flags", i), 32'(d1_rsp_flags), 32'(vecs[i].flags));
      chk($sformatf("v%0d_op_count", i), 32'(d1_op_count), 32'(i + 1));
      chk($sformatf("v%0d_idle", i), 32'({d1_busy, d1_ack0, d1_ack1}), 32'd0);
      step();
      chk($sformatf("v%0d_rsp_pulse_end", i), 32'(d1_rsp_valid), 32'd0);
      chk($sformatf("v%0d_rsp_hold", i), 32'({d1_rsp_result, d1_rsp_flags}),
          32'({vecs[i].res, vecs[i].flags}));
    end

    // Contention straight after reset: port 0 first, then port 1, then port 0 again
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    d1_req0 = 1'b1; d1_a0 = 7'h01; d1_b0 = 7'h02; d1_op0 = 3'b000;
    d1_req1 = 1'b1; d1_a1 = 7'h10; d1_b1 = 7'h20; d1_op1 = 3'b000;
    step();
    chk("cont_first_acks", 32'({d1_ack0, d1_ack1}), 32'b10);
    chk("cont_first_alu_a", 32'(d1_alu_a), 32'h01);
    d1_req0 = 1'b0;
    step();
    chk("cont_rsp0", 32'({d1_rsp_valid, d1_rsp_id, d1_rsp_result}), 32'({1'b1, 1'b0, 7'h03}));
    chk("cont_no_ack_in_exec", 32'({d1_ack0, d1_ack1}), 32'b00);
    step();
    chk("cont_second_acks", 32'({d1_ack0, d1_ack1}), 32'b01);
    chk("cont_second_alu_a", 32'(d1_alu_a), 32'h10);
    d1_req1 = 1'b0;
    step();
    chk("cont_rsp1", 32'({d1_rsp_valid, d1_rsp_id, d1_rsp_result, d1_rsp_flags}),
        32'({1'b1, 1'b1, 7'h30, 4'b0000}));
    d1_req0 = 1'b1; d1_req1 = 1'b1;
    step();
    chk("cont_alternate_acks", 32'({d1_ack0, d1_ack1}), 32'b10);
    d1_req0 = 1'b0;
    step();
    step();
    chk("cont_then_port1", 32'({d1_ack0, d1_ack1}), 32'b01);
    d1_req1 = 1'b0;
    step();
    step();

    // Reset in the middle of an ALU_LAT=3 operation, then continuous req0
    d3_req0 = 1'b1; d3_a0 = 7'h11; d3_b0 = 7'h22; d3_op0 = 3'b000;
    step();
    chk("lat3_first_ack", 32'({d3_ack0, d3_busy}), 32'b11);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(d3_busy), 32'd0);
    chk("midrst_alu", 32'({d3_alu_a, d3_alu_b, d3_alu_op}), 32'd0);
    chk("midrst_outs", 32'({d3_ack0, d3_rsp_valid, d3_op_count}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_no_rsp", 32'({d3_rsp_valid, d3_op_count}), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      if (d3_ack0) found = 1;
      else chk("postrst_wait_no_rsp", 32'(d3_rsp_valid), 32'd0);
    end
    chk("postrst_ack_seen", 32'(found), 32'd1);
    for (int k = 0; k < 16; k++) begin
      ph_exp = {((k % 4) == 0), ((k % 4) != 3), ((k % 4) == 3)};
      chk($sformatf("lat3_phase%0d", k), 32'({d3_ack0, d3_busy, d3_rsp_valid}), 32'(ph_exp));
      if ((k % 4) == 3)
        chk($sformatf("lat3_rsp%0d", k), 32'({d3_rsp_id, d3_rsp_result}), 32'({1'b0, 7'h33}));
      if (k < 15) step();
    end
    chk("lat3_op_count", 32'(d3_op_count), 32'd4);
    d3_req0 = 1'b0;
    step();
    chk("lat3_idle_after", 32'({d3_ack0, d3_busy}), 32'd0);

    // Saturation: 260 operations on the ALU_LAT=1 instance
    d1_req0 = 1'b1; d1_a0 = 7'h01; d1_b0 = 7'h01; d1_op0 = 3'b000;
    pulses = 0;
    for (int k = 0; k < 700 && pulses < 260; k++) begin
      step();
      if (d1_rsp_valid) begin
        pulses++;
        if (pulses == 254) chk("sat_count_254", 32'(d1_op_count), 32'd254);
        if (pulses == 255) chk("sat_count_255", 32'(d1_op_count), 32'd255);
      end
    end
    d1_req0 = 1'b0;
    chk("sat_pulses", 32'(pulses), 32'd260);
    chk("sat_final", 32'(d1_op_count), 32'd255);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
